// File: rtl/opl_timer_bank_pkg.sv
// opl_timer_bank_pkg: shared OPL timer constants
package opl_timer_bank_pkg;

    localparam int REG_TIMER_WIDTH      = 8;
    localparam int DEF_NUM_TIMERS       = 2;
    localparam int TICK_DIV_W           = 4;
    localparam int CLK_FREQ_HZ          = 3_600_000;
    // 80 us base tick: CLK_FREQ_HZ / 12500 clk cycles (288 at 3.6 MHz)
    localparam int OPL_BASE_TICK_CYCLES = CLK_FREQ_HZ / 12_500;

endpackage

// File: rtl/opl_timer_channel.sv
// opl_timer_channel: one auto-reload interval timer with tick sub-divider and start edge detect
module opl_timer_channel
    import opl_timer_bank_pkg::*;
#(
    parameter int                    TIMER_WIDTH = REG_TIMER_WIDTH,
    parameter logic [TICK_DIV_W-1:0] DIV         = 4'd1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   base_tick,
    input  logic                   start,
    input  logic [TIMER_WIDTH-1:0] load,
    output logic                   ovf_set,
    output logic                   overflow_pulse
);

    logic                   start_prev_q, start_prev_d;
    logic                   armed_q, armed_d;
    logic [TICK_DIV_W-1:0]  sub_q, sub_d;
    logic [TIMER_WIDTH-1:0] cnt_q, cnt_d;
    logic                   pulse_q;
    logic                   rise, sub_wrap;

    // Start edge wins over ticks; the channel only counts after an edge has armed it
    always_comb begin
        rise         = start & ~start_prev_q;
        sub_wrap     = sub_q == DIV - 4'd1;
        start_prev_d = start;
        armed_d      = armed_q | rise;
        sub_d        = sub_q;
        cnt_d        = cnt_q;
        ovf_set      = 1'b0;
        if (rise) begin
            cnt_d = load;
            sub_d = '0;
        end else if (start && armed_q && base_tick) begin
            sub_d = sub_wrap ? '0 : sub_q + 4'd1;
            if (sub_wrap) begin
                ovf_set = &cnt_q;
                cnt_d   = ovf_set ? load : cnt_q + TIMER_WIDTH'(1);
            end
        end
    end

    // State registers; reset captures start so a level held through reset is not an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            start_prev_q <= start;
            armed_q      <= 1'b0;
            sub_q        <= '0;
            cnt_q        <= '0;
            pulse_q      <= 1'b0;
        end else begin
            start_prev_q <= start_prev_d;
            armed_q      <= armed_d;
            sub_q        <= sub_d;
            cnt_q        <= cnt_d;
            pulse_q      <= ovf_set;
        end
    end

    assign overflow_pulse = pulse_q;

endmodule

// File: rtl/opl_timer_bank.sv
// opl_timer_bank: N interval timers sharing a base prescaler, with maskable sticky flags and IRQ
module opl_timer_bank
    import opl_timer_bank_pkg::*;
#(
    parameter int                               NUM_TIMERS       = DEF_NUM_TIMERS,
    parameter int                               TIMER_WIDTH      = REG_TIMER_WIDTH,
    parameter int                               BASE_TICK_CYCLES = OPL_BASE_TICK_CYCLES,
    parameter logic [NUM_TIMERS*TICK_DIV_W-1:0] TICK_DIV         = {4'd4, 4'd1}
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_TIMERS*TIMER_WIDTH-1:0] timer_load,
    input  logic [NUM_TIMERS-1:0]             start,
    input  logic [NUM_TIMERS-1:0]             mask,
    input  logic                              irq_reset,
    output logic [NUM_TIMERS-1:0]             overflow_pulse,
    output logic [NUM_TIMERS-1:0]             flag,
    output logic                              irq
);

    localparam int PW = $clog2(BASE_TICK_CYCLES);

    logic [PW-1:0]         pre_q, pre_d;
    logic                  base_tick;
    logic [NUM_TIMERS-1:0] ovf_set;
    logic [NUM_TIMERS-1:0] flag_q, flag_d;

    // Free-running prescaler and sticky flags; a new overflow beats a same-cycle irq_reset
    always_comb begin
        base_tick = pre_q == PW'(BASE_TICK_CYCLES - 1);
        pre_d     = base_tick ? '0 : pre_q + PW'(1);
        flag_d    = (flag_q & ~{NUM_TIMERS{irq_reset}}) | (ovf_set & ~mask);
    end

    // Prescaler and flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q  <= '0;
            flag_q <= '0;
        end else begin
            pre_q  <= pre_d;
            flag_q <= flag_d;
        end
    end

    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
        opl_timer_channel #(
            .TIMER_WIDTH (TIMER_WIDTH),
            .DIV         (TICK_DIV[i*TICK_DIV_W +: TICK_DIV_W])
        ) u_ch (
            .clk            (clk),
            .reset          (reset),
            .base_tick      (base_tick),
            .start          (start[i]),
            .load           (timer_load[i*TIMER_WIDTH +: TIMER_WIDTH]),
            .ovf_set        (ovf_set[i]),
            .overflow_pulse (overflow_pulse[i])
        );
    end

    assign flag = flag_q;
    assign irq  = |flag_q;

endmodule
